// File: rtl/lidar_motor_pwm_ramp.sv
// Soft-start PWM drive for the lidar spin motor: the enable level ramps the duty up or down
// at a programmable rate, and target duty and ramp interval are set over an Avalon-MM slave.
module lidar_motor_pwm_ramp #(
    parameter int PWM_BITS     = 8,
    parameter int RAMP_W       = 16,
    parameter int RAMP_DEFAULT = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        motor_en,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        pwm_out,
    output logic        at_speed
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RUN       = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } state_t;

    localparam logic [PWM_BITS-1:0] DUTY_ZERO    = '0;
    localparam logic [PWM_BITS-1:0] DUTY_ONE     = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX     = '1;
    localparam logic [PWM_BITS-1:0] CNT_LAST     = DUTY_MAX - DUTY_ONE;
    localparam logic [RAMP_W-1:0]   PRESC_ONE    = RAMP_W'(1);
    localparam logic [RAMP_W-1:0]   INTERVAL_RST = RAMP_W'(RAMP_DEFAULT);

    state_t              state_q, state_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PWM_BITS-1:0] target_q, target_d;
    logic [RAMP_W-1:0]   interval_q, interval_d;
    logic [RAMP_W-1:0]   presc_q, presc_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic                pwm_q, pwm_d;
    logic                at_speed_q, at_speed_d;

    logic                wr_en;
    logic                tick;
    logic [PWM_BITS-1:0] duty_inc;
    logic [PWM_BITS-1:0] duty_dec;

    assign wr_en = chipselect & ~write_n;
    assign tick  = (presc_q == interval_q);

    // Saturating steps so the duty can never wrap at either end.
    assign duty_inc = (duty_q == DUTY_MAX)  ? duty_q : duty_q + DUTY_ONE;
    assign duty_dec = (duty_q == DUTY_ZERO) ? duty_q : duty_q - DUTY_ONE;

    // Register file writes; upper write bits beyond each field are dropped.
    always_comb begin
        target_d   = target_q;
        interval_d = interval_q;
        if (wr_en) begin
            case (address)
                2'd0:    target_d   = writedata[PWM_BITS-1:0];
                2'd1:    interval_d = writedata[RAMP_W-1:0];
                default: ;
            endcase
        end
    end

    // Prescaler runs only outside IDLE; a shrunk interval below the count wraps naturally.
    always_comb begin
        presc_d = presc_q;
        if (state_q == ST_IDLE) begin
            presc_d = '0;
        end else if (tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PRESC_ONE;
        end
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        case (state_q)
            ST_IDLE: begin
                duty_d = DUTY_ZERO;
                if (motor_en) begin
                    state_d = ST_RAMP_UP;
                end
            end
            ST_RAMP_UP: begin
                if (!motor_en) begin
                    state_d = ST_RAMP_DOWN;
                end else if (duty_q >= target_q) begin
                    state_d = ST_RUN;
                end else if (tick) begin
                    duty_d = duty_inc;
                end
            end
            ST_RUN: begin
                if (!motor_en) begin
                    state_d = ST_RAMP_DOWN;
                end else if (tick) begin
                    if (duty_q < target_q) begin
                        duty_d = duty_inc;
                    end else if (duty_q > target_q) begin
                        duty_d = duty_dec;
                    end
                end
            end
            ST_RAMP_DOWN: begin
                if (motor_en) begin
                    state_d = ST_RAMP_UP;
                end else if (duty_q == DUTY_ZERO) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    duty_d = duty_dec;
                end
            end
            default: begin
                state_d = ST_IDLE;
                duty_d  = DUTY_ZERO;
            end
        endcase
    end

    // PWM period is one short of 2**PWM_BITS so that full-scale duty is constant high.
    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? DUTY_ZERO : cnt_q + DUTY_ONE;
        pwm_d = (cnt_q < duty_q);
    end

    assign at_speed_d = (state_d == ST_RUN) && (duty_d == target_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            duty_q     <= DUTY_ZERO;
            target_q   <= DUTY_ZERO;
            interval_q <= INTERVAL_RST;
            presc_q    <= '0;
            cnt_q      <= DUTY_ZERO;
            pwm_q      <= 1'b0;
            at_speed_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            target_q   <= target_d;
            interval_q <= interval_d;
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            pwm_q      <= pwm_d;
            at_speed_q <= at_speed_d;
        end
    end

    // Zero-wait-state read mux; the status word also serves as the FSM debug view.
    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata[PWM_BITS-1:0] = target_q;
            2'd1: readdata[RAMP_W-1:0]   = interval_q;
            2'd2: begin
                readdata[PWM_BITS-1:0] = duty_q;
                readdata[9:8]          = state_q;
                readdata[10]           = at_speed_q;
            end
            default: readdata = '0;
        endcase
    end

    assign pwm_out  = pwm_q;
    assign at_speed = at_speed_q;

endmodule

// File: tb/tb_lidar_motor_pwm_ramp.sv
// Bench for lidar_motor_pwm_ramp: directed ramp scenarios plus randomized enable/register
// traffic, every cycle compared against a behavioural model of the duty/state/PWM rules.
module tb_lidar_motor_pwm_ramp;

    localparam int S_IDLE = 0;
    localparam int S_UP   = 1;
    localparam int S_RUN  = 2;
    localparam int S_DOWN = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        motor_en = 1'b0;
    logic [1:0]  address = 2'd2;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        pwm_out;
    logic        at_speed;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_state, m_duty, m_target, m_interval, m_presc, m_phase;
    int m_pwm, m_at_speed;

    lidar_motor_pwm_ramp dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .motor_en   (motor_en),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .pwm_out    (pwm_out),
        .at_speed   (at_speed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic model_reset();
        m_state    = S_IDLE;
        m_duty     = 0;
        m_target   = 0;
        m_interval = 50000;
        m_presc    = 0;
        m_phase    = 0;
        m_pwm      = 0;
        m_at_speed = 0;
    endtask

    function automatic int model_read(input int a);
        case (a)
            0:       return m_target;
            1:       return m_interval;
            2:       return (m_at_speed << 10) | (m_state << 8) | m_duty;
            default: return 0;
        endcase
    endfunction

    // One clock of the behavioural rules, using the inputs present at this edge.
    task automatic model_step();
        int  ns, nd, np;
        bit  en, tick;
        en   = motor_en;
        tick = (m_presc == m_interval);
        ns   = m_state;
        nd   = m_duty;
        case (m_state)
            S_IDLE: begin
                nd = 0;
                if (en) ns = S_UP;
            end
            S_UP: begin
                if (!en) ns = S_DOWN;
                else if (m_duty >= m_target) ns = S_RUN;
                else if (tick) nd = (m_duty < 255) ? m_duty + 1 : 255;
            end
            S_RUN: begin
                if (!en) ns = S_DOWN;
                else if (tick && m_duty < m_target) nd = m_duty + 1;
                else if (tick && m_duty > m_target) nd = m_duty - 1;
            end
            default: begin
                if (en) ns = S_UP;
                else if (m_duty == 0) ns = S_IDLE;
                else if (tick) nd = m_duty - 1;
            end
        endcase
        if (m_state == S_IDLE || tick) np = 0;
        else np = (m_presc + 1) % 65536;
        m_pwm      = (m_phase < m_duty) ? 1 : 0;
        m_phase    = (m_phase + 1) % 255;
        m_at_speed = (ns == S_RUN && nd == m_target) ? 1 : 0;
        if (chipselect && !write_n) begin
            if (address == 2'd0) m_target = writedata & 32'hFF;
            if (address == 2'd1) m_interval = writedata & 32'hFFFF;
        end
        m_state = ns;
        m_duty  = nd;
        m_presc = np;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("pwm_out", {31'd0, pwm_out}, m_pwm);
        check("at_speed", {31'd0, at_speed}, m_at_speed);
        check("readdata", readdata, model_read(int'(address)));
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        cycle();
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd2;
    endtask

    task automatic wait_duty(input int v, input int budget, input string tag);
        int n = 0;
        address = 2'd2;
        while (m_duty != v && n < budget) begin
            cycle();
            n++;
        end
        check(tag, {24'd0, readdata[7:0]}, v);
    endtask

    task automatic wait_state(input int s, input int budget, input string tag);
        int n = 0;
        address = 2'd2;
        while (m_state != s && n < budget) begin
            cycle();
            n++;
        end
        check(tag, {30'd0, readdata[9:8]}, s);
    endtask

    task automatic count_pwm(input int n, output int highs);
        highs = 0;
        for (int i = 0; i < n; i++) begin
            cycle();
            if (pwm_out) highs++;
        end
    endtask

    task automatic check_reset_regs(input string tag);
        address = 2'd1;
        #1 check({tag, "_interval"}, readdata, 50000);
        address = 2'd0;
        #1 check({tag, "_target"}, readdata, 0);
        address = 2'd2;
        #1 check({tag, "_status"}, readdata, 0);
    endtask

    // Asynchronous reset mid-cycle: outputs must clear without waiting for an edge.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #3 reset_n = 1'b0;
        address = 2'd2;
        #1;
        check({tag, "_pwm"}, {31'd0, pwm_out}, 0);
        check({tag, "_at_speed"}, {31'd0, at_speed}, 0);
        check({tag, "_duty"}, readdata, 0);
        model_reset();
        motor_en = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check_reset_regs(tag);
    endtask

    initial begin
        int n, highs, min_duty, as_highs;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset values and quiet output
        check_reset_regs("reset");
        count_pwm(1000, highs);
        check("reset_pwm_highs", highs, 0);

        // Ramp up: interval 3, target 10
        bus_write(2'd1, 32'd3);
        bus_write(2'd0, 32'd10);
        motor_en = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!at_speed && n < 100);
        check("ramp_up_latency", n, 42);
        check("ramp_up_status", readdata, (1 << 10) | (S_RUN << 8) | 10);
        count_pwm(255, highs);
        check("pwm_duty10_highs", highs, 10);

        // Ramp down to IDLE
        motor_en = 1'b0;
        wait_state(S_IDLE, 200, "ramp_down_idle");
        check("ramp_down_status", readdata, 0);
        count_pwm(300, highs);
        check("ramp_down_pwm_highs", highs, 0);

        // Reversal without passing through zero
        bus_write(2'd1, 32'd0);
        bus_write(2'd0, 32'd200);
        motor_en = 1'b1;
        wait_duty(50, 300, "rev_reach50");
        motor_en = 1'b0;
        wait_duty(45, 300, "rev_reach45");
        motor_en = 1'b1;
        min_duty = 255;
        n = 0;
        while (!(m_state == S_RUN && m_duty == 200) && n < 400) begin
            cycle();
            if (int'(readdata[7:0]) < min_duty) min_duty = int'(readdata[7:0]);
            n++;
        end
        check("rev_min_duty", min_duty, 45);
        cycle();
        check("rev_run200_status", readdata, (1 << 10) | (S_RUN << 8) | 200);

        // Retarget while running
        bus_write(2'd0, 32'd100);
        as_highs = 0;
        n = 0;
        while (m_duty != 100 && n < 300) begin
            cycle();
            if (m_duty != 100 && at_speed) as_highs++;
            n++;
        end
        check("retarget_slew_at_speed", as_highs, 0);
        check("retarget_duty100", {24'd0, readdata[7:0]}, 100);
        check("retarget_at_speed100", {31'd0, at_speed}, 1);
        bus_write(2'd0, 32'd255);
        wait_duty(255, 400, "retarget_duty255");
        cycle();
        count_pwm(255, highs);
        check("pwm_full_highs", highs, 255);

        // Async reset mid RAMP_UP at duty 30
        motor_en = 1'b0;
        wait_state(S_IDLE, 600, "pre_async_idle");
        bus_write(2'd0, 32'd100);
        bus_write(2'd1, 32'd2);
        motor_en = 1'b1;
        wait_duty(30, 400, "async_reach30");
        check("async_state_up", {30'd0, readdata[9:8]}, S_UP);
        async_reset("async");
        for (int i = 0; i < 20; i++) cycle();

        // Randomized traffic
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 39) == 0) motor_en = ~motor_en;
            if ($urandom_range(0, 59) == 0)
                bus_write(2'd0, $urandom);
            else if (m_state == S_IDLE && $urandom_range(0, 29) == 0)
                bus_write(2'd1, ($urandom & 32'hFFFF_0000) | $urandom_range(0, 5));
            else if ($urandom_range(0, 99) == 0)
                bus_write(2'($urandom_range(2, 3)), $urandom);
            else if ($urandom_range(0, 2499) == 0)
                async_reset("rand_async");
            else begin
                address = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
                cycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
